// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer: fetches operands from a 4x4 register file, runs
// the 4-bit ALU op set and hands the result out over a valid/ready port.
module alu_sequencer #(
    parameter int CNT_W     = 8,
    parameter int MUL_EXTRA = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [8:0]       instr,
    input  logic             load_en,
    input  logic [1:0]       load_addr,
    input  logic [3:0]       load_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [3:0]       res_data,
    output logic [1:0]       res_addr,
    output logic             busy,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {IDLE, READ, EXEC, MUL, WB} state_t;

    localparam bit         HAS_MUL  = (MUL_EXTRA > 0);
    localparam logic [1:0] DLY_INIT = HAS_MUL ? 2'(MUL_EXTRA - 1) : 2'd0;

    state_t     state, state_n;
    logic [2:0] op;
    logic [1:0] rs, rt, rd;
    logic [3:0] opa, opb;
    logic [1:0] dly;
    logic [3:0] rf [4];
    logic [3:0] alu_y;
    logic [7:0] prod;
    logic       is_mul;

    assign is_mul      = (op == 3'b111);
    assign instr_ready = (state == IDLE) && !load_en;
    assign busy        = (state != IDLE);
    assign res_valid   = (state == WB);
    assign prod        = {4'b0, opa} * {4'b0, opb};

    always_comb begin
        alu_y = '0;
        unique case (op)
            3'b000: alu_y = opa + opb;
            3'b001: alu_y = opa + ~opb;
            3'b010: alu_y = opa + 4'd1;
            3'b011: alu_y = ~(opa | opb);
            3'b100: alu_y = ~(opa & opb);
            3'b101: alu_y = opa >> 2;
            3'b110: alu_y = opa << 1;
            3'b111: alu_y = prod[3:0];
            default: alu_y = '0;
        endcase
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (!load_en && instr_valid) state_n = READ;
            READ: state_n = EXEC;
            EXEC: state_n = (is_mul && HAS_MUL) ? MUL : WB;
            MUL:  if (dly == 2'd0) state_n = WB;
            WB:   if (res_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            op       <= '0;
            rs       <= '0;
            rt       <= '0;
            rd       <= '0;
            opa      <= '0;
            opb      <= '0;
            dly      <= '0;
            res_data <= '0;
            res_addr <= '0;
            retired  <= '0;
            for (int i = 0; i < 4; i++) rf[i] <= '0;
        end else begin
            state <= state_n;
            unique case (state)
                IDLE: begin
                    // a direct load takes priority over accepting an instruction
                    if (load_en)
                        rf[load_addr] <= load_data;
                    else if (instr_valid)
                        {op, rs, rt, rd} <= instr;
                end
                READ: begin
                    opa <= rf[rs];
                    opb <= rf[rt];
                end
                EXEC: begin
                    if (is_mul && HAS_MUL) begin
                        dly <= DLY_INIT;
                    end else begin
                        res_data <= alu_y;
                        res_addr <= rd;
                    end
                end
                MUL: begin
                    if (dly == 2'd0) begin
                        res_data <= alu_y;
                        res_addr <= rd;
                    end else begin
                        dly <= dly - 2'd1;
                    end
                end
                WB: begin
                    if (res_ready) begin
                        rf[rd]  <= res_data;
                        retired <= retired + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: vector table for the op set plus
// hand sequences for backpressure, load priority, mid-op reset and wrap.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [8:0] instr;
    logic       load_en;
    logic [1:0] load_addr;
    logic [3:0] load_data;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;
    logic [1:0] res_addr;
    logic       busy;
    logic [7:0] retired;

    int checks = 0;
    int errors = 0;

    alu_sequencer #(.CNT_W(8), .MUL_EXTRA(1)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_addr(res_addr),
        .busy(busy), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [3:0] exp_data;
        int         exp_lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic load(input logic [1:0] a, input logic [3:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(posedge clk); @(negedge clk);
        load_en = 1'b0;
    endtask

    // called and returns at a negedge with the DUT idle
    task automatic do_instr(input logic [8:0] ins, input bit ld_busy,
                            output logic [3:0] d, output logic [1:0] a,
                            output int lat);
        instr = ins; instr_valid = 1'b1; res_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        instr_valid = 1'b0;
        if (ld_busy) begin
            load_en = 1'b1; load_addr = 2'd1; load_data = 4'hF;
        end
        lat = 0;
        while (!res_valid && lat < 20) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        d = res_data; a = res_addr;
        @(posedge clk); @(negedge clk);
        load_en = 1'b0;
    endtask

    vec_t       vecs [8];
    logic [3:0] d;
    logic [1:0] a;
    int         lat;

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{3'b000, 4'h1, 2};
        vecs[1] = '{3'b001, 4'h4, 2};
        vecs[2] = '{3'b010, 4'hC, 2};
        vecs[3] = '{3'b011, 4'h0, 2};
        vecs[4] = '{3'b100, 4'hD, 2};
        vecs[5] = '{3'b101, 4'h2, 2};
        vecs[6] = '{3'b110, 4'h6, 2};
        vecs[7] = '{3'b111, 4'h2, 3};

        rst = 1'b1; instr_valid = 1'b0; instr = '0; load_en = 1'b0;
        load_addr = '0; load_data = '0; res_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_out", {instr_ready, busy, res_valid, res_data, res_addr, retired},
            {1'b1, 1'b0, 1'b0, 4'h0, 2'd0, 8'd0});
        rst = 1'b0;

        load(2'd0, 4'h5);
        load(2'd1, 4'h3);
        do_instr({3'b000, 2'd0, 2'd1, 2'd2}, 1'b0, d, a, lat);
        chk("add_data", d, 4'h8);
        chk("add_addr", a, 2'd2);
        chk("add_lat", lat, 2);
        chk("ready_after", {res_valid, instr_ready}, 2'b01);
        do_instr({3'b010, 2'd2, 2'd0, 2'd2}, 1'b0, d, a, lat);
        chk("inc_fwd", d, 4'h9);
        chk("retired2", retired, 8'd2);

        load(2'd0, 4'hB);
        load(2'd1, 4'h6);
        for (int i = 0; i < 8; i++) begin
            do_instr({vecs[i].op, 2'd0, 2'd1, 2'd3}, 1'b0, d, a, lat);
            chk($sformatf("op%0d_data", i), d, vecs[i].exp_data);
            chk($sformatf("op%0d_addr", i), a, 2'd3);
            chk($sformatf("op%0d_lat", i), lat, vecs[i].exp_lat);
        end
        do_instr({3'b010, 2'd3, 2'd0, 2'd3}, 1'b0, d, a, lat);
        chk("r3_after_mul", d, 4'h3);
        chk("retired11", retired, 8'd11);

        // backpressure: result held while consumer stalls
        instr = {3'b000, 2'd0, 2'd1, 2'd2}; instr_valid = 1'b1; res_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        instr_valid = 1'b0;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_hold%0d", i),
                {res_valid, res_data, res_addr, instr_ready, retired},
                {1'b1, 4'h1, 2'd2, 1'b0, 8'd11});
            @(posedge clk); @(negedge clk);
        end
        res_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("bp_release", {res_valid, retired}, {1'b0, 8'd12});
        do_instr({3'b010, 2'd2, 2'd0, 2'd3}, 1'b0, d, a, lat);
        chk("bp_rd_written", d, 4'h2);

        // load and instruction offered together
        load_en = 1'b1; load_addr = 2'd0; load_data = 4'h7;
        instr = {3'b010, 2'd0, 2'd0, 2'd3}; instr_valid = 1'b1;
        #1 chk("load_blocks_ready", instr_ready, 1'b0);
        @(posedge clk); @(negedge clk);
        load_en = 1'b0;
        #1 chk("ready_after_load", {instr_ready, busy}, 2'b10);
        do_instr({3'b010, 2'd0, 2'd0, 2'd3}, 1'b0, d, a, lat);
        chk("uses_loaded", d, 4'h8);

        do_instr({3'b010, 2'd1, 2'd0, 2'd3}, 1'b1, d, a, lat);
        chk("busy_load_res", d, 4'h7);
        do_instr({3'b010, 2'd1, 2'd0, 2'd3}, 1'b0, d, a, lat);
        chk("busy_load_ignored", d, 4'h7);

        // reset while the multiply is stretching
        instr = {3'b111, 2'd0, 2'd1, 2'd2}; instr_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        instr_valid = 1'b0;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        chk("mul_pending", {busy, res_valid}, 2'b10);
        rst = 1'b1;
        #1 chk("async_rst", {instr_ready, busy, res_valid, res_data, res_addr, retired},
               {1'b1, 1'b0, 1'b0, 4'h0, 2'd0, 8'd0});
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        do_instr({3'b000, 2'd0, 2'd1, 2'd2}, 1'b0, d, a, lat);
        chk("post_rst_add", d, 4'h0);
        do_instr({3'b010, 2'd2, 2'd0, 2'd3}, 1'b0, d, a, lat);
        chk("mul_rd_not_written", d, 4'h1);

        for (int i = 0; i < 253; i++)
            do_instr({3'b000, 2'd0, 2'd0, 2'd0}, 1'b0, d, a, lat);
        chk("retired255", retired, 8'd255);
        do_instr({3'b000, 2'd0, 2'd0, 2'd0}, 1'b0, d, a, lat);
        chk("retired_wrap", retired, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
